// File: rtl/mem_burst_arbiter.sv
// rtl/mem_burst_arbiter.sv - round-robin arbiter sharing one burst memory port between two refill engines
// A watchdog aborts stalled bursts with a synthetic last beat to the owner.
module mem_burst_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_req,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [LEN_WIDTH-1:0]  s0_burst_len,
  output logic                  s0_ready,
  output logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_valid,
  output logic                  s0_last,
  input  logic                  s1_req,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [LEN_WIDTH-1:0]  s1_burst_len,
  output logic                  s1_ready,
  output logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_valid,
  output logic                  s1_last,
  output logic                  m_req,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_WIDTH-1:0]  m_burst_len,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_valid,
  input  logic                  m_last,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_e;

  state_e                state_q, state_d;
  logic [1:0]            pend_q, pend_d, pend_clr;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [LEN_WIDTH-1:0]  len0_q, len1_q;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;

  logic                  cap0, cap1;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [LEN_WIDTH-1:0]  own_len;
  logic                  wd_hit, fwd, burst_end, abort;
  logic                  own_valid, own_last;
  logic [DATA_WIDTH-1:0] own_data;

  assign s0_ready = ~pend_q[0];
  assign s1_ready = ~pend_q[1];
  assign cap0     = s0_req & ~pend_q[0];
  assign cap1     = s1_req & ~pend_q[1];
  assign own_addr = owner_q ? addr1_q : addr0_q;
  assign own_len  = owner_q ? len1_q : len0_q;
  assign wd_hit   = WD_EN && (idle_cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    pend_clr     = 2'b00;
    m_req        = 1'b0;
    m_addr       = '0;
    m_burst_len  = '0;
    fwd          = 1'b0;
    burst_end    = 1'b0;
    abort        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          // on a tie, the port that was not served last wins
          owner_d    = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          idle_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        m_req       = 1'b1;
        m_addr      = own_addr;
        m_burst_len = own_len;
        idle_cnt_d  = idle_cnt_q + CNT_W'(1);
        if (wd_hit) begin
          abort = 1'b1;
        end else if (m_ready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        fwd       = 1'b1;
        burst_end = m_valid & (m_last | (beat_cnt_q == own_len));
        if (m_valid) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
        abort = wd_hit & ~burst_end;
      end
      default: state_d = IDLE;
    endcase
    if (burst_end || abort) begin
      pend_clr     = owner_q ? 2'b10 : 2'b01;
      last_grant_d = owner_q;
      state_d      = IDLE;
    end
  end

  assign pend_d    = (pend_q & ~pend_clr) | {cap1, cap0};
  assign own_valid = abort | (fwd & m_valid);
  assign own_last  = abort | burst_end;
  assign own_data  = (fwd && !abort) ? m_data : '0;

  assign s0_valid    = own_valid & ~owner_q;
  assign s0_last     = own_last & ~owner_q;
  assign s0_data     = owner_q ? '0 : own_data;
  assign s1_valid    = own_valid & owner_q;
  assign s1_last     = own_last & owner_q;
  assign s1_data     = owner_q ? own_data : '0;
  assign grant_id    = owner_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 2'b00;
      addr0_q      <= '0;
      addr1_q      <= '0;
      len0_q       <= '0;
      len1_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      if (cap0) begin
        addr0_q <= s0_addr;
        len0_q  <= s0_burst_len;
      end
      if (cap1) begin
        addr1_q <= s1_addr;
        len1_q  <= s1_burst_len;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb/tb_mem_burst_arbiter.sv - directed and randomized bench for mem_burst_arbiter
// Outputs are compared every cycle against a transaction-level model kept below.
module tb_mem_burst_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_req = 0, s1_req = 0;
  logic [AW-1:0] s0_addr = 0, s1_addr = 0;
  logic [LW-1:0] s0_burst_len = 0, s1_burst_len = 0;
  logic          s0_ready, s1_ready, s0_valid, s1_valid, s0_last, s1_last;
  logic [DW-1:0] s0_data, s1_data;
  logic          m_req, m_ready, m_valid, m_last;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_burst_len;
  logic [DW-1:0] m_data;
  logic          grant_id, busy, timeout_err;

  mem_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_addr(s0_addr), .s0_burst_len(s0_burst_len), .s0_ready(s0_ready),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
    .s1_req(s1_req), .s1_addr(s1_addr), .s1_burst_len(s1_burst_len), .s1_ready(s1_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
    .m_req(m_req), .m_addr(m_addr), .m_burst_len(m_burst_len), .m_ready(m_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // memory responder controls (written by the main process only)
  int          mem_mode = 0;   // 0 normal, 1 no m_last plus a stray beat, 2 accept then silent
  int          mem_gap  = 0;
  logic [31:0] mem_base = 0;
  bit          mem_busy = 0;

  initial begin : responder
    int mode, nb, d, g;
    logic [31:0] base;
    m_ready = 0; m_valid = 0; m_last = 0; m_data = 0;
    forever begin
      @(negedge clk);
      if (m_req && !rst) begin
        mem_busy = 1;
        mode = mem_mode;
        nb   = int'(m_burst_len) + 1;
        base = mem_base;
        d    = (mem_gap == 0) ? 0 : $urandom_range(0, mem_gap);
        repeat (d + 1) @(posedge clk);
        #1 m_ready = 1;
        @(posedge clk);
        #1 m_ready = 0;
        if (mode != 2) begin
          for (int i = 0; i < nb; i++) begin
            g = (mem_gap == 0) ? 0 : $urandom_range(0, mem_gap);
            if (g > 0) begin
              repeat (g) @(posedge clk);
              #1;
            end
            m_valid = 1;
            m_data  = base + 32'(i);
            m_last  = (mode == 0) && (i == nb - 1);
            @(posedge clk);
            #1 m_valid = 0; m_last = 0;
          end
        end
        if (mode == 1) begin
          m_valid = 1; m_data = 32'hDEAD_BEEF;
          @(posedge clk);
          #1 m_valid = 0;
        end
        mem_busy = 0;
      end
    end
  end

  // model: pending requests, the burst in flight and the watchdog, tracked as plain values
  bit          md_ok = 0;
  bit          md_pend[2];
  logic [31:0] md_addr[2];
  logic [3:0]  md_len[2];
  int          md_phase;   // 0 no burst, 1 request outstanding, 2 receiving beats
  bit          md_own, md_lastg;
  int          md_beats, md_quiet;

  logic [32:0] rx0[$], rx1[$], gq[$];
  int          tcount = 0;
  bit          prev_mreq = 0;

  always @(negedge clk) begin : compare
    bit done, abort, fin, cap0, cap1, vld, lst;
    logic [31:0] dat;
    logic [109:0] act, exp;
    bit ev[2], el[2];
    logic [31:0] ed[2];
    done  = md_phase == 2 && m_valid && (m_last || md_beats == int'(md_len[md_own]));
    abort = md_phase != 0 && md_quiet == TO - 1 && !done;
    vld   = (md_phase == 2 && m_valid) || abort;
    lst   = done || abort;
    dat   = (md_phase == 2 && !abort) ? m_data : 32'h0;
    ev[0] = 0; ev[1] = 0; el[0] = 0; el[1] = 0; ed[0] = 0; ed[1] = 0;
    if (md_phase != 0) begin
      ev[md_own] = vld; el[md_own] = lst; ed[md_own] = dat;
    end
    exp = {!md_pend[0], !md_pend[1], md_phase == 1,
           (md_phase == 1) ? md_addr[md_own] : 32'h0, (md_phase == 1) ? md_len[md_own] : 4'h0,
           md_phase != 0, (md_phase != 0) ? md_own : 1'b0, abort,
           ev[0], el[0], ed[0], ev[1], el[1], ed[1]};
    act = {s0_ready, s1_ready, m_req, m_addr, m_burst_len, busy, busy ? grant_id : 1'b0, timeout_err,
           s0_valid, s0_last, s0_data, s1_valid, s1_last, s1_data};
    if (md_ok) chk("cycle", 128'(act), 128'(exp));

    if (s0_valid) rx0.push_back({s0_last, s0_data});
    if (s1_valid) rx1.push_back({s1_last, s1_data});
    if (m_req && !prev_mreq) gq.push_back({grant_id, m_addr});
    if (timeout_err) tcount++;
    prev_mreq = m_req;

    if (rst) begin
      md_ok = 1; md_pend[0] = 0; md_pend[1] = 0; md_phase = 0;
      md_own = 0; md_lastg = 1; md_beats = 0; md_quiet = 0;
      md_addr[0] = 0; md_addr[1] = 0; md_len[0] = 0; md_len[1] = 0;
    end else if (md_ok) begin
      cap0 = s0_req && !md_pend[0];
      cap1 = s1_req && !md_pend[1];
      fin  = 0;
      case (md_phase)
        0: if (md_pend[0] || md_pend[1]) begin
             md_own   = (md_pend[0] && md_pend[1]) ? !md_lastg : md_pend[1];
             md_phase = 1;
             md_quiet = 0;
           end
        1: if (abort) fin = 1;
           else begin
             md_quiet++;
             if (m_ready) begin md_phase = 2; md_beats = 0; end
           end
        default: if (done || abort) fin = 1;
                 else if (m_valid) begin md_beats++; md_quiet = 0; end
                 else md_quiet++;
      endcase
      if (fin) begin
        md_pend[md_own] = 0; md_lastg = md_own; md_phase = 0;
      end
      if (cap0) begin md_pend[0] = 1; md_addr[0] = s0_addr; md_len[0] = s0_burst_len; end
      if (cap1) begin md_pend[1] = 1; md_addr[1] = s1_addr; md_len[1] = s1_burst_len; end
    end
  end

  task automatic pulse(input bit p0, input bit p1, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] l0, input logic [3:0] l1);
    @(posedge clk);
    #1 s0_req = p0; s1_req = p1; s0_addr = a0; s1_addr = a1; s0_burst_len = l0; s1_burst_len = l1;
    @(posedge clk);
    #1 s0_req = 0; s1_req = 0;
  endtask

  task automatic wait_quiet(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || !s0_ready || !s1_ready || mem_busy) && n < 300);
    chk({nm, "_settle"}, 128'(n >= 300), 128'(0));
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin : main
    int g0, r0, r1, t0, n;
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int g0, r0, r1, t0, n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_state", 128'({s0_ready, s1_ready, m_req, busy, timeout_err, s0_valid, s1_valid,
                             s0_last, s1_last, grant_id}), 128'(10'b1100000000));
    chk("reset_data", 128'({m_addr, s0_data, s1_data}), 128'(0));

    // tie right after reset: port 0 first
    mem_mode = 0; mem_gap = 1; mem_base = 32'h10;
    g0 = gq.size();
    pulse(1, 1, 32'h100, 32'h200, 4'd2, 4'd1);
    wait_quiet("tie1");
    chk("tie1_count", 128'(gq.size() - g0), 128'(2));
    chk("tie1_first", 128'(gq[g0]), 128'({1'b0, 32'h100}));
    chk("tie1_second", 128'(gq[g0 + 1]), 128'({1'b1, 32'h200}));

    // single burst, fixed timing
    mem_mode = 0; mem_gap = 0; mem_base = 32'hA0;
    r0 = rx0.size(); r1 = rx1.size();
    pulse(1, 0, 32'h100, 32'h0, 4'd3, 4'd0);
    @(negedge clk);
    chk("single_mreq_t1", 128'(m_req), 128'(0));
    @(negedge clk);
    chk("single_mreq_t2", 128'({m_req, m_addr, m_burst_len}), 128'({1'b1, 32'h100, 4'd3}));
    wait_quiet("single");
    chk("single_beats", 128'(rx0.size() - r0), 128'(4));
    for (int i = 0; i < 4; i++)
      chk("single_beat", 128'(rx0[r0 + i]), 128'({i == 3, 32'hA0 + 32'(i)}));
    chk("single_s1_quiet", 128'(rx1.size() - r1), 128'(0));

    // tie after port 0 was served last: port 1 first
    mem_mode = 0; mem_gap = 1; mem_base = 32'h20;
    g0 = gq.size();
    pulse(1, 1, 32'h100, 32'h200, 4'd0, 4'd0);
    wait_quiet("tie2");
    chk("tie2_first", 128'(gq[g0]), 128'({1'b1, 32'h200}));
    chk("tie2_second", 128'(gq[g0 + 1]), 128'({1'b0, 32'h100}));

    // missing m_last, followed by a stray beat
    mem_mode = 1; mem_gap = 0; mem_base = 32'hB0;
    r1 = rx1.size();
    pulse(0, 1, 32'h0, 32'h240, 4'd0, 4'd1);
    wait_quiet("nolast");
    chk("nolast_beats", 128'(rx1.size() - r1), 128'(2));
    chk("nolast_b0", 128'(rx1[r1]), 128'({1'b0, 32'hB0}));
    chk("nolast_b1", 128'(rx1[r1 + 1]), 128'({1'b1, 32'hB1}));

    // watchdog abort
    mem_mode = 2; mem_gap = 0;
    r0 = rx0.size(); t0 = tcount;
    pulse(1, 0, 32'h180, 32'h0, 4'd5, 4'd0);
    wait_quiet("timeout");
    chk("timeout_pulses", 128'(tcount - t0), 128'(1));
    chk("timeout_beats", 128'(rx0.size() - r0), 128'(1));
    chk("timeout_beat", 128'(rx0[r0]), 128'({1'b1, 32'h0}));

    // reset in the middle of a burst
    mem_mode = 0; mem_gap = 0; mem_base = 32'hC0;
    r0 = rx0.size();
    pulse(1, 0, 32'h1C0, 32'h0, 4'd3, 4'd0);
    n = 0;
    while (rx0.size() - r0 < 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("rstmid_reach", 128'(n >= 50), 128'(0));
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rstmid_outputs", 128'({s0_ready, s1_ready, m_req, busy, timeout_err, s0_valid, s1_valid,
                                s0_last, s1_last}), 128'(9'b110000000));
    wait_quiet("rstmid");
    chk("rstmid_beats", 128'(rx0.size() - r0), 128'(3));
    mem_base = 32'hD0;
    r1 = rx1.size();
    pulse(0, 1, 32'h0, 32'h2C0, 4'd0, 4'd2);
    wait_quiet("rstmid_after");
    chk("rstmid_new_beats", 128'(rx1.size() - r1), 128'(3));
    chk("rstmid_new_last", 128'(rx1[r1 + 2]), 128'({1'b1, 32'hD2}));

    // duplicate request while pending
    mem_mode = 0; mem_gap = 1; mem_base = 32'hE0;
    g0 = gq.size(); r0 = rx0.size();
    @(posedge clk); #1 s0_req = 1; s0_addr = 32'h100; s0_burst_len = 4'd1;
    @(posedge clk); #1 s0_addr = 32'h300; s0_burst_len = 4'd2;
    @(posedge clk); #1 s0_req = 0;
    wait_quiet("dup");
    chk("dup_txns", 128'(gq.size() - g0), 128'(1));
    chk("dup_addr", 128'(gq[g0]), 128'({1'b0, 32'h100}));
    chk("dup_beats", 128'(rx0.size() - r0), 128'(2));

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      s0_req = ($urandom_range(0, 5) == 0);
      s1_req = ($urandom_range(0, 5) == 0);
      s0_addr = $urandom; s1_addr = $urandom;
      s0_burst_len = 4'($urandom_range(0, 15));
      s1_burst_len = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 9);
      mem_mode = (n < 8) ? 0 : n - 7;
      mem_gap  = 1;
      mem_base = $urandom;
    end
    @(posedge clk); #1 s0_req = 0; s1_req = 0;
    wait_quiet("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
